// File: rtl/fpnew_pkg.sv
// Shared FPU types: exception flag set and sizing helper for the result reorder buffer.
package fpnew_pkg;

   typedef struct packed {
      logic NV;  // invalid
      logic DZ;  // divide by zero
      logic OF;  // overflow
      logic UF;  // underflow
      logic NX;  // inexact
   } status_t;

   // Tag width needed to carry a reorder slot ID through an opgroup block.
   function automatic int unsigned reorder_id_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fpnew_result_reorder.sv
// In-order result collector: hands out slot IDs at issue, accepts tagged results in any
// order and retires them strictly in allocation order.
module fpnew_result_reorder
   import fpnew_pkg::*;
#(
   parameter  int unsigned Width   = 32,
   parameter  int unsigned Depth   = 4,
   localparam int unsigned IdWidth = $clog2(Depth)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               alloc_valid_i,
   output logic               alloc_ready_o,
   output logic [IdWidth-1:0] alloc_id_o,
   input  logic               wb_valid_i,
   output logic               wb_ready_o,
   input  logic [IdWidth-1:0] wb_id_i,
   input  logic [Width-1:0]   wb_result_i,
   input  status_t            wb_status_i,
   input  logic               wb_ext_bit_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [Width-1:0]   result_o,
   output status_t            status_o,
   output logic               extension_bit_o,
   output logic               wb_err_o,
   output logic               busy_o
);

   typedef struct packed {
      logic [Width-1:0] result;
      status_t          status;
      logic             ext_bit;
   } slot_t;

   logic [IdWidth:0]   head_q, tail_q;
   logic [Depth-1:0]   pending_q, done_q;
   slot_t              slot_q [Depth];
   logic               wb_err_q;

   logic [IdWidth-1:0] head_idx, tail_idx;
   logic               empty, full;
   logic               alloc_fire, retire_fire, wb_ok, wb_bad;

   assign head_idx = head_q[IdWidth-1:0];
   assign tail_idx = tail_q[IdWidth-1:0];
   assign empty    = (head_q == tail_q);
   assign full     = (head_idx == tail_idx) && (head_q[IdWidth] != tail_q[IdWidth]);

   // Ready looks only at the registered fullness: a same-cycle retire does not free a slot.
   assign alloc_ready_o = !full && !flush_i;
   assign alloc_id_o    = tail_idx;
   assign wb_ready_o    = 1'b1;

   assign out_valid_o     = !empty && done_q[head_idx];
   assign result_o        = slot_q[head_idx].result;
   assign status_o        = slot_q[head_idx].status;
   assign extension_bit_o = slot_q[head_idx].ext_bit;
   assign busy_o          = !empty;
   assign wb_err_o        = wb_err_q;

   assign alloc_fire  = alloc_valid_i && alloc_ready_o;
   assign retire_fire = out_valid_o && out_ready_i;
   assign wb_ok       = wb_valid_i && pending_q[wb_id_i] && !done_q[wb_id_i];
   assign wb_bad      = wb_valid_i && !wb_ok;

   // Alloc slot (tail), write-back slot and retire slot (head) never collide: tail==head
   // only when empty or full, and a write-back to a done head is rejected as illegal.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         pending_q <= '0;
         done_q    <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         wb_err_q  <= 1'b0;
      end else begin
         if (alloc_fire) begin
            pending_q[tail_idx] <= 1'b1;
            done_q[tail_idx]    <= 1'b0;
            tail_q              <= tail_q + (IdWidth+1)'(1);
         end
         if (wb_ok) begin
            done_q[wb_id_i] <= 1'b1;
         end
         if (retire_fire) begin
            pending_q[head_idx] <= 1'b0;
            done_q[head_idx]    <= 1'b0;
            head_q              <= head_q + (IdWidth+1)'(1);
         end
         wb_err_q <= wb_bad;
      end
   end

   // Payload storage carries no reset; control bits alone decide what is visible.
   always_ff @(posedge clk_i) begin
      if (wb_ok && !flush_i && !rst_i) begin
         slot_q[wb_id_i] <= {wb_result_i, wb_status_i, wb_ext_bit_i};
      end
   end

endmodule

// File: doc/fpnew_result_reorder.md
Name: fpnew_result_reorder

Overview:
- In-order result collector placed upstream of an opgroup block.
- Allocates a slot ID per issued operation; the ID travels to the opgroup block as its tag.
- Accepts results back in any order, since format slices have differing latencies and the round-robin arbiter reorders them.
- Retires results strictly in allocation order over a valid/ready stream.

Parameters:
- Width, 32: result width in bits.
- Depth, 4: number of in-flight slots; must be a power of two and at least 2.
- IdWidth, $clog2(Depth): localparam; slot ID width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all in-flight slots.
- alloc_valid_i  in  1  request a slot for a newly issued op.
- alloc_ready_o  out  1  slot available.
- alloc_id_o  out  IdWidth  ID granted on alloc handshake.
- wb_valid_i  in  1  result write-back from the opgroup arbiter.
- wb_ready_o  out  1  always 1 (write-back never stalls).
- wb_id_i  in  IdWidth  slot ID of the result (the returned tag).
- wb_result_i  in  Width  result data.
- wb_status_i  in  fpnew_pkg::status_t  exception flags.
- wb_ext_bit_i  in  1  extension bit.
- out_valid_o  out  1  head slot complete.
- out_ready_i  in  1  consumer accepts.
- result_o  out  Width  head result.
- status_o  out  fpnew_pkg::status_t  head flags.
- extension_bit_o  out  1  head extension bit.
- wb_err_o  out  1  one-cycle pulse on an illegal write-back.
- busy_o  out  1  any slot pending.

Behaviour:
- State:
  - Per slot: pending, done, result, status, ext_bit.
  - head_q and tail_q pointers, each IdWidth+1 bits (wrap bit).
- Pointer conditions:
  - empty = (head_q == tail_q).
  - full = index bits equal and wrap bits differ.
- Allocation:
  - alloc_ready_o = !full && !flush_i.
  - alloc_id_o = tail_q[IdWidth-1:0].
  - On handshake: slot[tail].pending=1, done=0, tail_q++.
  - No bypass: while full, alloc_ready_o stays 0 even if a retire happens in the same cycle.
- Write-back:
  - Accepted when slot[wb_id_i].pending && !done: stores data, sets done=1.
  - Write-back to a non-pending slot or an already-done slot: data ignored; wb_err_o=1 in the next cycle (registered).
  - A write-back to the ID being allocated in the same cycle is illegal (the slot is not yet pending).
- Retire:
  - out_valid_o = !empty && slot[head].done.
  - Data outputs are driven from slot[head].
  - Outputs are held stable while out_valid_o && !out_ready_i.
  - On handshake: slot[head].pending=0, done=0, head_q++.
- Latency:
  - Write-back to out_valid_o is at least 1 cycle, because of the registered done bit.
  - Allocation to write-back is at least 1 cycle.
- Simultaneous events in one cycle are independent: alloc, write-back to any other slot, and retire of head. Write-back to head and retire of head in the same cycle cannot occur, because out_valid_o requires done to already be set.
- Wrap-around:
  - Pointers wrap modulo 2*Depth.
  - After Depth allocations and retires, IDs repeat starting from 0.
- Throughput: one alloc, one write-back and one retire per cycle, sustained.
- Flush (flush_i):
  - Next cycle: all pending/done bits are 0 and head_q = tail_q = 0.
  - Flush dominates any alloc, write-back or retire in the same cycle.
  - wb_err_o is not raised for that cycle.
- Reset (rst_i), including mid-operation: same clearing as flush. Reset values:
  - out_valid_o=0, busy_o=0, wb_err_o=0, alloc_id_o=0.
  - alloc_ready_o=1 once reset is deasserted.
  - Data outputs are don't-care but must not be X-driven into control.
- busy_o = !empty.

Decomposition:
- fpnew_pkg: add a function reorder_id_width(depth) for users that size TagType. The existing status_t is reused.
- The slot entry struct {result, status, ext_bit} stays local to the module, since it depends on Width.
- No sub-module. Single module; a plain register array with a read mux on head.

Test Plan:
- In-order results: alloc ids 0,1,2; write-backs 0xA,0xB,0xC to ids 0,1,2 on consecutive cycles -> out 0xA,0xB,0xC, each valid at least 1 cycle after its write-back.
- Out-of-order results: alloc 0..3; write-backs to 3,1,2 with 0x33,0x11,0x22 -> out_valid_o=0 throughout. Then write-back to 0 with 0x00 -> retires 0x00,0x11,0x22,0x33 in that order on 4 consecutive cycles with out_ready_i=1.
- Full/backpressure: Depth=4, 4 allocs -> alloc_ready_o=0. Complete id0 and hold out_ready_i=0 for 5 cycles -> result_o stable. Retire -> alloc_ready_o=1 the next cycle; next alloc_id_o=0 (wrap).
- Illegal write-back: write-back to id 2 with no allocation -> wb_err_o pulses 1 cycle and the slot remains not done. Double write-back to a done slot -> wb_err_o pulses and the first data is kept.
- Flush mid-flight: 3 pending, 1 done. Assert flush_i together with alloc_valid_i -> next cycle busy_o=0, out_valid_o=0, alloc_id_o=0, and the alloc is not taken.
- Reset mid-operation: rst_i=1 for 1 cycle with 2 slots done -> outputs at reset values. Then alloc returns id 0.
